// File: rtl/serial_ram_rw.sv
// Pin-serial RAM port: address, write data and read data each move as CYCLES narrow
// slices per frame, with a fixed-latency read pipeline and a one-frame-deferred write.
module serial_ram_rw #(
   parameter int unsigned ADDR_PINS     = 4,
   parameter int unsigned DATA_PINS     = 4,
   parameter int unsigned LOG2_CYCLES   = 2,
   parameter int unsigned RAM_ADDR_BITS = 12,
   parameter int unsigned DELAY         = 2,
   parameter int unsigned WRITE_EN      = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [ADDR_PINS-1:0] addr_in,
   input  logic                 we_in,
   input  logic [DATA_PINS-1:0] data_in,
   output logic [DATA_PINS-1:0] data_out,
   output logic                 sync_out
);

   localparam int unsigned CYCLES     = 1 << LOG2_CYCLES;
   localparam int unsigned WORD_BITS  = DATA_PINS * CYCLES;
   localparam int unsigned FRAME_BITS = ADDR_PINS * CYCLES;
   localparam int unsigned PHASE_BITS = (LOG2_CYCLES > 0) ? LOG2_CYCLES : 1;
   localparam int unsigned DEPTH      = 1 << RAM_ADDR_BITS;
   localparam logic [PHASE_BITS-1:0] LAST_PHASE = PHASE_BITS'(CYCLES - 1);
   // The word register holds slice 0 right after the phase-0 read, i.e. while phase is 1.
   localparam logic [PHASE_BITS-1:0] MARK_PHASE = PHASE_BITS'(1 % CYCLES);

   logic [PHASE_BITS-1:0]    phase_q;
   logic [FRAME_BITS-1:0]    addr_q;
   logic [WORD_BITS-1:0]     word_q;
   logic [DATA_PINS-1:0]     line_q [DELAY];
   logic [DELAY-1:0]         mark_q;
   logic                     pend_q;
   logic [RAM_ADDR_BITS-1:0] wr_addr_q;
   logic [WORD_BITS-1:0]     wr_data_q;
   logic [WORD_BITS-1:0]     mem [DEPTH];

   logic [FRAME_BITS-1:0]    frame_addr;
   logic [WORD_BITS-1:0]     wr_word;
   logic [RAM_ADDR_BITS-1:0] rd_addr;
   logic                     last_phase;
   logic                     commit;
   logic                     unused_addr_bits;

   always_comb begin
      frame_addr = addr_q;
      frame_addr[(CYCLES-1)*ADDR_PINS +: ADDR_PINS] = addr_in;
      wr_word = wr_data_q;
      wr_word[(CYCLES-1)*DATA_PINS +: DATA_PINS] = data_in;
      rd_addr    = addr_q[RAM_ADDR_BITS-1:0];
      last_phase = (phase_q == LAST_PHASE);
      commit     = (WRITE_EN != 0) && enable && !reset && pend_q && last_phase;
   end

   // Address bits above the RAM depth alias away.
   assign unused_addr_bits = ^frame_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q   <= '0;
         addr_q    <= '0;
         word_q    <= '0;
         mark_q    <= '0;
         pend_q    <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         for (int unsigned i = 0; i < DELAY; i++) line_q[i] <= '0;
      end else if (enable) begin
         phase_q <= last_phase ? '0 : phase_q + 1'b1;
         addr_q[phase_q*ADDR_PINS +: ADDR_PINS] <= addr_in;

         if (phase_q == '0) word_q <= mem[rd_addr];
         else               word_q <= word_q >> DATA_PINS;

         line_q[0] <= word_q[DATA_PINS-1:0];
         mark_q[0] <= (phase_q == MARK_PHASE);
         for (int unsigned i = 1; i < DELAY; i++) begin
            line_q[i] <= line_q[i-1];
            mark_q[i] <= mark_q[i-1];
         end

         if (WRITE_EN != 0) begin
            if (pend_q) wr_data_q[phase_q*DATA_PINS +: DATA_PINS] <= data_in;
            // Commit and re-arm share this edge, so back-to-back writes need no gap.
            if (last_phase) begin
               pend_q    <= we_in;
               wr_addr_q <= frame_addr[RAM_ADDR_BITS-1:0];
            end
         end
      end
   end

   // Memory has no reset; its contents survive reset.
   always_ff @(posedge clk) begin
      if (commit) mem[wr_addr_q] <= wr_word;
   end

   assign data_out = line_q[DELAY-1];
   assign sync_out = mark_q[DELAY-1];

endmodule

// File: tb/tb_serial_ram_rw.sv
// Bench for serial_ram_rw: drives DELAY=2 and DELAY=1 instances with identical frames and
// checks both against a frame-level memory model (reads return whole words, writes land per frame).
module tb_serial_ram_rw;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] addr_in = '0;
   logic       we_in = 1'b0;
   logic [3:0] data_in = '0;
   logic [3:0] dout2, dout1;
   logic       sync2, sync1;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [15:0] mem_m [4096];
   bit          known_m [4096];
   logic [15:0] r_word [int];
   bit          r_known [int];
   int          n;
   logic [15:0] cur_addr, cur_data;
   logic [11:0] prev_addr, pend_addr;
   bit          pend;
   logic [3:0]  exp_d2, exp_d1;
   logic        exp_s2, exp_s1;
   bit          exp_k2, exp_k1;

   // Outputs seen after each enabled edge since the last reset
   logic [3:0] cap2_d [$];
   logic [3:0] cap1_d [$];
   logic       cap2_s [$];
   logic       cap1_s [$];

   serial_ram_rw #(.DELAY(2)) dut2 (
      .clk(clk), .reset(reset), .enable(enable), .addr_in(addr_in), .we_in(we_in),
      .data_in(data_in), .data_out(dout2), .sync_out(sync2));

   serial_ram_rw #(.DELAY(1)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .addr_in(addr_in), .we_in(we_in),
      .data_in(data_in), .data_out(dout1), .sync_out(sync1));

   always #5 clk = ~clk;

   // Slice m = E0-relative position of the word read at frame m/4
   task automatic expect_at(input int e, input int dd, output logic [3:0] d, output logic s,
                            output bit k);
      int m;
      logic [15:0] w;
      m = e - dd;
      if (m < 0) begin
         d = '0; s = 1'b0; k = 1'b1;
      end else begin
         w = r_word[m / 4];
         d = w[4*(m % 4) +: 4];
         s = ((m % 4) == 0);
         k = r_known[m / 4];
      end
   endtask

   task automatic tick(input bit en, input bit rst, input logic [3:0] a, input logic w,
                       input logic [3:0] d);
      int k;
      reset = rst; enable = en; addr_in = a; we_in = w; data_in = d;
      @(posedge clk);
      #1;
      if (rst) begin
         n = 0; cur_addr = '0; prev_addr = '0; pend = 1'b0;
      end else if (en) begin
         k = n % 4;
         if (k == 0) begin
            r_word[n / 4]  = mem_m[prev_addr];
            r_known[n / 4] = known_m[prev_addr];
         end
         cur_addr[4*k +: 4] = a;
         cur_data[4*k +: 4] = d;
         if (k == 3) begin
            if (pend) begin
               mem_m[pend_addr]   = cur_data;
               known_m[pend_addr] = 1'b1;
            end
            pend      = w;
            pend_addr = cur_addr[11:0];
            prev_addr = cur_addr[11:0];
         end
         n++;
      end
      expect_at(n - 1, 2, exp_d2, exp_s2, exp_k2);
      expect_at(n - 1, 1, exp_d1, exp_s1, exp_k1);
   endtask

   task automatic do_reset(input bit en);
      tick(en, 1'b1, 4'($urandom), 1'($urandom), 4'($urandom));
      cap2_d.delete(); cap1_d.delete(); cap2_s.delete(); cap1_s.delete();
      tests++; if (dout2 !== 4'h0) begin fails++; $display("FAIL reset_d2: got %h want 0", dout2); end
      tests++; if (sync2 !== 1'b0) begin fails++; $display("FAIL reset_s2: got %b want 0", sync2); end
      tests++; if (dout1 !== 4'h0) begin fails++; $display("FAIL reset_d1: got %h want 0", dout1); end
      tests++; if (sync1 !== 1'b0) begin fails++; $display("FAIL reset_s1: got %b want 0", sync1); end
   endtask

   // One frame of up to nph phases; optional disabled cycles after phase stall_ph
   task automatic frame(input logic [15:0] a, input logic w, input logic [15:0] d,
                        input int nph = 4, input int stall_ph = -1, input int stall_n = 0);
      for (int k = 0; k < nph; k++) begin
         for (int j = 0; j <= ((k == stall_ph) ? stall_n : 0); j++) begin
            if (j == 0) tick(1'b1, 1'b0, a[4*k +: 4], (k == 3) ? w : 1'($urandom), d[4*k +: 4]);
            else        tick(1'b0, 1'b0, 4'($urandom), 1'($urandom), 4'($urandom));
            if (exp_k2) begin
               tests++;
               if (dout2 !== exp_d2) begin
                  fails++;
                  $display("FAIL model_d2 edge %0d stall %0d: got %h want %h", n - 1, j, dout2, exp_d2);
               end
            end
            tests++;
            if (sync2 !== exp_s2) begin
               fails++;
               $display("FAIL model_s2 edge %0d stall %0d: got %b want %b", n - 1, j, sync2, exp_s2);
            end
            if (exp_k1) begin
               tests++;
               if (dout1 !== exp_d1) begin
                  fails++;
                  $display("FAIL model_d1 edge %0d stall %0d: got %h want %h", n - 1, j, dout1, exp_d1);
               end
            end
            tests++;
            if (sync1 !== exp_s1) begin
               fails++;
               $display("FAIL model_s1 edge %0d stall %0d: got %b want %b", n - 1, j, sync1, exp_s1);
            end
            if (j == 0) begin
               cap2_d.push_back(dout2); cap2_s.push_back(sync2);
               cap1_d.push_back(dout1); cap1_s.push_back(sync1);
            end
         end
      end
   endtask

   function automatic logic [15:0] word2(int e);
      return {cap2_d[e+3], cap2_d[e+2], cap2_d[e+1], cap2_d[e]};
   endfunction

   function automatic logic [15:0] word1(int e);
      return {cap1_d[e+3], cap1_d[e+2], cap1_d[e+1], cap1_d[e]};
   endfunction

   task automatic test_reset;
      do_reset(1'b0);
      frame(16'h0abc, 1'b0, 16'h0000, 2);
      do_reset(1'b1);
   endtask

   task automatic test_write_read;
      do_reset(1'b1);
      frame(16'h0123, 1'b1, 16'h0000);
      frame(16'h0000, 1'b0, 16'hbeef);
      frame(16'h0123, 1'b0, 16'h0000);
      frame(16'h0000, 1'b0, 16'h0000);
      frame(16'h0000, 1'b0, 16'h0000);
      tests++; if (word2(14) !== 16'hbeef) begin fails++; $display("FAIL wr_rd_word2: got %h want beef", word2(14)); end
      tests++; if (word1(13) !== 16'hbeef) begin fails++; $display("FAIL wr_rd_word1: got %h want beef", word1(13)); end
      tests++; if (cap2_s[14] !== 1'b1) begin fails++; $display("FAIL wr_rd_sync_e2: got %b want 1", cap2_s[14]); end
      for (int e = 15; e <= 17; e++) begin
         tests++;
         if (cap2_s[e] !== 1'b0) begin fails++; $display("FAIL wr_rd_sync_low edge %0d: got %b want 0", e, cap2_s[e]); end
      end
      tests++; if (cap2_s[13] !== 1'b0) begin fails++; $display("FAIL wr_rd_sync_e1: got %b want 0", cap2_s[13]); end
   endtask

   task automatic test_read_before_write;
      do_reset(1'b1);
      frame(16'h0010, 1'b1, 16'h0000);
      frame(16'h0000, 1'b0, 16'h9999);
      frame(16'h0010, 1'b1, 16'h0000);
      frame(16'h0010, 1'b0, 16'h1234);
      frame(16'h0000, 1'b0, 16'h0000);
      frame(16'h0000, 1'b0, 16'h0000);
      tests++; if (word2(14) !== 16'h9999) begin fails++; $display("FAIL rbw_old: got %h want 9999", word2(14)); end
      tests++; if (word2(18) !== 16'h1234) begin fails++; $display("FAIL rbw_new: got %h want 1234", word2(18)); end
      tests++; if (cap2_d[18] !== 4'h4) begin fails++; $display("FAIL rbw_first_slice: got %h want 4", cap2_d[18]); end
   endtask

   task automatic test_back_to_back;
      do_reset(1'b1);
      frame(16'h0001, 1'b1, 16'h0000);
      frame(16'h0002, 1'b1, 16'haaaa);
      frame(16'h0001, 1'b0, 16'h5555);
      frame(16'h0002, 1'b0, 16'h0000);
      frame(16'h0000, 1'b0, 16'h0000);
      frame(16'h0000, 1'b0, 16'h0000);
      tests++; if (word2(14) !== 16'haaaa) begin fails++; $display("FAIL b2b_first: got %h want aaaa", word2(14)); end
      tests++; if (word2(18) !== 16'h5555) begin fails++; $display("FAIL b2b_second: got %h want 5555", word2(18)); end
   endtask

   task automatic test_stall;
      logic [15:0] v;
      v = 16'($urandom);
      do_reset(1'b1);
      frame(16'h0123, 1'b1, 16'h0000);
      frame(16'h0000, 1'b0, v);
      frame(16'h0123, 1'b0, 16'h0000);
      frame(16'h0000, 1'b0, 16'h0000);
      frame(16'h0000, 1'b0, 16'h0000, 4, 0, 3);
      tests++; if (word2(14) !== v) begin fails++; $display("FAIL stall_word: got %h want %h", word2(14), v); end
      tests++; if (cap2_s[14] !== 1'b1) begin fails++; $display("FAIL stall_sync: got %b want 1", cap2_s[14]); end
   endtask

   task automatic test_reset_mid_write;
      logic [15:0] v;
      v = 16'($urandom_range(0, 16'hdeac));
      do_reset(1'b1);
      frame(16'h00ff, 1'b1, 16'h0000);
      frame(16'h0000, 1'b0, v);
      frame(16'h00ff, 1'b1, 16'h0000);
      frame(16'h0000, 1'b0, 16'hdead, 2);
      do_reset(1'b1);
      frame(16'h00ff, 1'b0, 16'h0000);
      frame(16'h0000, 1'b0, 16'h0000);
      frame(16'h0000, 1'b0, 16'h0000);
      tests++; if (word2(6) !== v) begin fails++; $display("FAIL rst_mid_write: got %h want %h", word2(6), v); end
   endtask

   task automatic test_alias;
      do_reset(1'b1);
      frame(16'h1fff, 1'b1, 16'h0000);
      frame(16'h0000, 1'b0, 16'h0ffe);
      frame(16'h0fff, 1'b0, 16'h0000);
      frame(16'h0000, 1'b0, 16'h0000);
      frame(16'h0000, 1'b0, 16'h0000);
      tests++; if (word1(13) !== 16'h0ffe) begin fails++; $display("FAIL alias_d1: got %h want 0ffe", word1(13)); end
      tests++; if (cap1_s[13] !== 1'b1) begin fails++; $display("FAIL alias_sync_d1: got %b want 1", cap1_s[13]); end
      tests++; if (cap1_s[12] !== 1'b0) begin fails++; $display("FAIL alias_sync_early: got %b want 0", cap1_s[12]); end
      tests++; if (word2(14) !== 16'h0ffe) begin fails++; $display("FAIL alias_d2: got %h want 0ffe", word2(14)); end
   endtask

   task automatic test_random;
      do_reset(1'b1);
      for (int f = 0; f < 80; f++) begin
         if ($urandom_range(0, 11) == 0) begin
            frame(16'($urandom) & 16'hf003, 1'($urandom), 16'($urandom), $urandom_range(1, 3));
            do_reset(1'($urandom));
         end else begin
            frame(16'($urandom) & 16'hf003, 1'($urandom), 16'($urandom), 4,
                  $urandom_range(0, 7), $urandom_range(1, 3));
         end
      end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_read_before_write;
      test_back_to_back;
      test_stall;
      test_reset_mid_write;
      test_alias;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_ram_rw.md
SERIAL_RAM_RW -- requirements
Module: serial_ram_rw

Interface
REQ-001 SHALL have parameter ADDR_PINS, default 4: address pins per cycle.
REQ-002 SHALL have parameter DATA_PINS, default 4: data pins per cycle, in each direction.
REQ-003 SHALL have parameter LOG2_CYCLES, default 2: CYCLES = 2**LOG2_CYCLES enabled cycles per frame.
REQ-004 SHALL have parameter RAM_ADDR_BITS, default 12: memory depth 2**RAM_ADDR_BITS words of DATA_PINS*CYCLES bits; legal range 1..ADDR_PINS*CYCLES.
REQ-005 SHALL have parameter DELAY, default 2: output pipeline stages; legal range >= 1.
REQ-006 SHALL have parameter WRITE_EN, default 1: 0 disables all write logic and ignores we_in and data_in.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port enable, input, 1 bit: high means advance one phase; low means freeze all state.
REQ-010 SHALL have port addr_in, input, ADDR_PINS bits: address slice, LSB slice first.
REQ-011 SHALL have port we_in, input, 1 bit: write request, sampled at phase CYCLES-1.
REQ-012 SHALL have port data_in, input, DATA_PINS bits: write data slice, LSB slice first.
REQ-013 SHALL have port data_out, output, DATA_PINS bits: read data slice.
REQ-014 SHALL have port sync_out, output, 1 bit: high while data_out carries slice 0 of a word.

Function
REQ-015 SHALL keep a phase counter 0..CYCLES-1; it increments on each enabled edge and wraps to 0; one full count is one frame.
REQ-016 SHALL capture addr_in into address slice k on the enabled edge at phase k.
REQ-017 SHALL perform a RAM read on the enabled edge at phase 0, using the address assembled in the previous frame (lower RAM_ADDR_BITS bits), and load the read word into the word register.
REQ-018 SHALL shift the word register right by DATA_PINS on enabled edges at phases 1..CYCLES-1.
REQ-019 SHALL, on every enabled edge, push the word register's low slice into a DELAY-deep shift line; data_out is the oldest stage.
REQ-020 SHALL make latency exact: with E0 the phase-0 edge that reads word W, slice k of W is on data_out after enabled edge E0+k+DELAY, for k = 0..CYCLES-1.
REQ-021 SHALL drive sync_out through a DELAY-matched marker so that it is high exactly when slice 0 is on data_out, and low otherwise.
REQ-022 SHALL (WRITE_EN=1) latch a pending write with the full frame address when we_in=1 on the phase CYCLES-1 edge of frame N.
REQ-023 SHALL, while a write is pending, capture data_in into data slice k on the phase-k edges of frame N+1.
REQ-024 SHALL commit the write on the phase CYCLES-1 edge of frame N+1 (slice CYCLES-1 taken from data_in on that edge) and then clear the pending flag.
REQ-025 SHALL make the read at the phase-0 edge of frame N+1 return pre-write contents (read-before-write).
REQ-026 SHALL make a read issued at frame N+2 to the same address return the new data.
REQ-027 SHALL start a new pending write if we_in=1 on the commit edge, allowing back-to-back writes; the new write's data is captured in the following frame.
REQ-028 SHALL, with enable=0, hold counter, address, word register, shift line, marker, pending write and outputs unchanged; the frame resumes where it stopped.
REQ-029 SHALL treat address bits above RAM_ADDR_BITS as ignored, so addresses alias modulo depth.

Reset
REQ-030 SHALL, on reset=1 at a clock edge regardless of enable, zero the counter, address register, word register, shift line and marker, and clear any pending write.
REQ-031 SHALL make data_out=0 and sync_out=0 from the first edge after reset.
REQ-032 SHALL leave memory contents unaltered by reset.
REQ-033 SHALL make a write interrupted by reset never commit.
REQ-034 SHALL begin the first frame after reset release at phase 0.

Verification (defaults, CYCLES=4, 16-bit words)
REQ-035 SHALL cover a basic write then read: frame with address 0x123 and we=1, next frame data_in F,E,E,B (0xBEEF), then address 0x123 with we=0 -> data_out F,E,E,B at E0+2..E0+5, with sync_out high only at E0+2.
REQ-036 SHALL cover read-before-write: write 0x1234 to 0x010, then in the data frame present address 0x010 -> the read during the data frame returns the old value, and the next frame's read returns 4,3,2,1.
REQ-037 SHALL cover back-to-back writes: write 0xAAAA to 0x001 and 0x5555 to 0x002 in consecutive frames -> both read back correctly.
REQ-038 SHALL cover an enable stall: drop enable for 3 cycles mid-frame during a read -> output sequence identical, shifted by 3 cycles, with no slice lost or repeated.
REQ-039 SHALL cover reset mid-write: assert reset at phase 2 of the data frame for a write of 0xDEAD to 0x0FF -> a later read of 0x0FF returns the prior contents, and data_out=0 immediately after reset.
REQ-040 SHALL cover aliasing and DELAY: with DELAY=1, writing 0x0C0FFE's low word to 0x1FFF reads back at 0x0FFF; slice 0 appears after E0+1.
